// File: rtl/alu32_cmd_issuer.sv
// Command front end for the 32-bit combinational ALU: buffers requests in an
// in-order FIFO, drives one command at a time and returns tagged results.
module alu32_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_op,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     alu_en,
  output logic [4:0]               alu_op,
  output logic [31:0]              alu_in1,
  output logic [31:0]              alu_in2,
  input  logic [32:0]              alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [32:0]              rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [4:0]  OP_DIV = 5'b00101;

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
      5'b00011, 5'b11000, 5'b00110, 5'b00101, 5'b01010: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alu_en_q, alu_en_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [32:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  cmd_t cmd_in, head;
  logic push, pop, fifo_empty, head_ok;

  assign cmd_in     = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign cmd_ready  = (count_q < CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // Divide by zero is reported as an error rather than handed to the ALU
  assign head_ok    = op_legal(head.op) && !((head.op == OP_DIV) && (head.b == 32'd0));

  // FIFO storage carries no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRIVE;
      DRIVE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = fifo_empty ? IDLE : DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    alu_en_d    = 1'b0;
    alu_op_d    = alu_op_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if ((state_q != DRIVE) && (state_d == DRIVE)) begin
      alu_en_d  = head_ok;
      alu_op_d  = head.op;
      alu_in1_d = head.a;
      alu_in2_d = head.b;
    end
    case (state_q)
      DRIVE: begin
        pop         = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_tag_d   = head.tag;
        rsp_data_d  = head_ok ? alu_out : 33'd0;
        rsp_err_d   = !head_ok;
      end
      RESP:    if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_en_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_en_q    <= alu_en_d;
      alu_op_q    <= alu_op_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_en    = alu_en_q;
  assign alu_op    = alu_op_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu32_cmd_issuer.sv
// Directed bench for alu32_cmd_issuer with a behavioural ALU and an in-order
// response scoreboard.
module tb_alu32_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [32:0] alu_out;
  logic        rsp_valid, rsp_ready;
  logic [32:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [2:0]  count;

  typedef struct packed {
    logic [32:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_cnt = 0;

  always #5 clk = ~clk;

  alu32_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_en(alu_en), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .count(count)
  );

  function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00000: alu_f = 33'(a) + 33'(b);
      5'b00001: alu_f = 33'(a) - 33'(b);
      5'b00010: alu_f = 33'(a) + 33'd1;
      5'b00100: alu_f = 33'(a) - 33'd1;
      5'b01000: alu_f = 33'(a & b);
      5'b00011: alu_f = 33'(a | b);
      5'b11000: alu_f = 33'(a ^ b);
      5'b00110: alu_f = 33'(~a);
      5'b00101: alu_f = (b == 32'd0) ? 33'd0 : 33'(a / b);
      5'b01010: alu_f = 33'(a << b[4:0]);
      default:  alu_f = 33'd0;
    endcase
  endfunction

  function automatic logic legal(input logic [4:0] op);
    legal = (op == 5'd0) || (op == 5'd1) || (op == 5'd2) || (op == 5'd4) || (op == 5'd8) ||
            (op == 5'd3) || (op == 5'd24) || (op == 5'd6) || (op == 5'd5) || (op == 5'd10);
  endfunction

  // Behavioural ALU: junk value whenever the enable is low
  assign alu_out = alu_en ? alu_f(alu_op, alu_in1, alu_in2) : 33'h0_DEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        done = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard: pop on response handshake, push on command acceptance
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (alu_en) en_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("sb_tag",  64'(rsp_tag),  64'(e.tag));
          chk("sb_data", 64'(rsp_data), 64'(e.data));
          chk("sb_err",  64'(rsp_err),  64'(e.err));
        end
      end
      if (cmd_valid && cmd_ready) begin
        e.tag = cmd_tag;
        e.err = !(legal(cmd_op) && !((cmd_op == 5'b00101) && (cmd_b == 32'd0)));
        e.data = e.err ? 33'd0 : alu_f(cmd_op, cmd_a, cmd_b);
        sb.push_back(e);
      end
    end
  end

  initial begin
    int acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_alu",       64'({alu_en, alu_op, alu_in1, alu_in2}), 64'd0);
    chk("rst_rsp",       64'({rsp_valid, rsp_tag, rsp_err}), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Add with latency and single-cycle enable
    rsp_ready = 1'b1; en_cnt = 0;
    send(5'b00000, 32'd5, 32'd7, 4'd3);
    chk("add_e0_valid", 64'(rsp_valid), 64'd0);
    chk("add_e0_count", 64'(count), 64'd1);
    tick();
    chk("add_drive_alu", 64'({alu_en, alu_op}), 64'({1'b1, 5'b00000}));
    chk("add_drive_in1", 64'(alu_in1), 64'd5);
    chk("add_drive_in2", 64'(alu_in2), 64'd7);
    chk("add_e1_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("add_valid", 64'(rsp_valid), 64'd1);
    chk("add_data",  64'(rsp_data),  64'd12);
    chk("add_tag",   64'(rsp_tag),   64'd3);
    chk("add_err",   64'(rsp_err),   64'd0);
    chk("add_en_low", 64'(alu_en),   64'd0);
    tick();
    chk("add_done_valid", 64'(rsp_valid), 64'd0);
    chk("add_en_cycles", 64'(en_cnt), 64'd1);

    // Subtract wrap
    send(5'b00001, 32'd0, 32'd1, 4'd5);
    wait_rsp();
    chk("sub_data", 64'(rsp_data), 64'h1_FFFF_FFFF);
    chk("sub_err",  64'(rsp_err),  64'd0);
    tick();

    // Error cases: divide by zero and illegal opcode
    en_cnt = 0;
    send(5'b00101, 32'd100, 32'd0, 4'd6);
    wait_rsp();
    chk("div0_err",  64'(rsp_err),  64'd1);
    chk("div0_data", 64'(rsp_data), 64'd0);
    tick();
    send(5'b11111, 32'd1, 32'd2, 4'd7);
    wait_rsp();
    chk("illegal_err",  64'(rsp_err),  64'd1);
    chk("illegal_data", 64'(rsp_data), 64'd0);
    tick();
    chk("err_en_never", 64'(en_cnt), 64'd0);
    send(5'b00101, 32'd100, 32'd7, 4'd8);
    send(5'b01010, 32'h1, 32'd31, 4'd9);
    send(5'b11000, 32'hF0F0_1234, 32'h0FF0_4321, 4'd10);
    for (int i = 0; i < 20 && (count != 3'd0 || rsp_valid); i++) tick();
    chk("mix_drained", 64'(sb.size()), 64'd0);

    // Backpressure: fill FIFO plus response register
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_valid = 1'b1; cmd_op = 5'b00000; cmd_tag = 4'(acc);
      cmd_a = 32'(acc + 10); cmd_b = 32'(acc);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted",  64'(acc),       64'd5);
    chk("bp_ready",     64'(cmd_ready), 64'd0);
    chk("bp_count",     64'(count),     64'd4);
    chk("bp_valid",     64'(rsp_valid), 64'd1);
    chk("bp_tag",       64'(rsp_tag),   64'd0);
    chk("bp_data",      64'(rsp_data),  64'd10);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_cadence", 64'(rsp_valid), 64'((i % 2) == 0));
      tick();
    end
    chk("bp_count_end", 64'(count), 64'd0);

    // Simultaneous push/pop around count = 3
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = 5'b00010; cmd_a = 32'(100 + i); cmd_b = '0; cmd_tag = 4'(8 + i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("sim_count3", 64'(count),   64'd3);
    chk("sim_tag8",   64'(rsp_tag), 64'd8);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 32'd200; cmd_tag = 4'd12;
    chk("sim_drive_en", 64'(alu_en), 64'd1);
    chk("sim_ready",    64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("sim_pushpop_count", 64'(count), 64'd3);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 32'd201; cmd_tag = 4'd13;
    tick();
    cmd_a = 32'd202; cmd_tag = 4'd14;
    chk("sim_full_count", 64'(count),     64'd4);
    chk("sim_full_ready", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("sim_reject_count", 64'(count), 64'd3);
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && (count != 3'd0 || rsp_valid); i++) tick();
    chk("sim_drained", 64'(sb.size()), 64'd0);

    // Reset during DRIVE with two commands buffered
    rsp_ready = 1'b0;
    send(5'b00000, 32'd1, 32'd1, 4'd1);
    send(5'b00000, 32'd2, 32'd2, 4'd2);
    send(5'b00000, 32'd3, 32'd3, 4'd3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("mid_drive_en", 64'(alu_en), 64'd1);
    chk("mid_count",    64'(count),  64'd2);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_alu",   64'({alu_en, alu_op, alu_in1, alu_in2}), 64'd0);
    chk("mid_rst_rsp",   64'({rsp_valid, rsp_tag, rsp_err}), 64'd0);
    chk("mid_rst_data",  64'(rsp_data), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_en",    64'(alu_en),    64'd0);
    send(5'b00010, 32'd41, 32'd0, 4'd9);
    wait_rsp();
    chk("post_rst_data", 64'(rsp_data), 64'd42);
    chk("post_rst_tag",  64'(rsp_tag),  64'd9);
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_count",    64'(count),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
